thread_fetch: RTL and testbench

Two-thread fine-grained interleaved instruction fetch stage for the 16-bit multithreaded core. Holds one program counter per thread, picks a thread round-robin each cycle, and reads instruction memory. It delivers instruction, PC and thread ID through a one-entry valid/ready output register to decode, which drives the register file's read thread ID. It also handles per-thread stall, branch redirect and halt.

---
 rtl/core_pkg.sv | 25 ++
 rtl/thread_select.sv | 25 ++
 rtl/thread_fetch.sv | 124 ++++++++++++
 tb/tb_thread_fetch.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit two-thread core: widths, halt opcode, reset PCs, fetch record.
// No logic of its own; used by the fetch stage and its thread picker.
// Fetch records are packed so they can be registered as a single bus.
package core_pkg;

  localparam int THREAD_W    = 1;
  localparam int NUM_THREADS = 2;
  localparam int DEF_PC_W    = 8;
  localparam int DEF_INSTR_W = 16;

  localparam logic [3:0]          HALT_OPCODE     = 4'hF;
  localparam logic [DEF_PC_W-1:0] T0_RESET_PC_DEF = 8'h00;
  localparam logic [DEF_PC_W-1:0] T1_RESET_PC_DEF = 8'h80;

  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_PC_W-1:0]    pc;
    logic [THREAD_W-1:0]    tid;
  } fetch_out_t;

  function automatic logic is_halt(input logic [DEF_INSTR_W-1:0] instr);
    return instr[DEF_INSTR_W-1 -: 4] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/thread_select.sv
// Round-robin picker between two threads; prefers rr, optionally falls back to the other thread.
// Latency: combinational.
// Backpressure: none here; the caller gates the result with its own advance condition.
module thread_select
  import core_pkg::*;
(
  input  logic [THREAD_W-1:0]    rr,
  input  logic [NUM_THREADS-1:0] eligible,
  input  logic                   skip_en,
  output logic [THREAD_W-1:0]    sel,
  output logic                   issue
);

  always_comb begin
    sel   = rr;
    issue = 1'b0;
    if (eligible[rr]) begin
      issue = 1'b1;
    end else if (skip_en && eligible[~rr]) begin
      sel   = ~rr;
      issue = 1'b1;
    end
  end

endmodule

// File: rtl/thread_fetch.sv
// Two-thread interleaved fetch with per-thread stall, redirect and halt; THREAD_SKIP_EN enables slot skipping.
// Latency: one cycle from imem_addr to out_*.
// Backpressure: one-entry valid/ready output register; PCs and rr hold while it is full and not accepted.
module thread_fetch
  import core_pkg::*;
#(
  parameter int              PC_W        = DEF_PC_W,
  parameter int              INSTR_W     = DEF_INSTR_W,
  parameter logic [PC_W-1:0] T0_RESET_PC = T0_RESET_PC_DEF,
  parameter logic [PC_W-1:0] T1_RESET_PC = T1_RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic [1:0]         thread_stall,
  input  logic               redirect_valid,
  input  logic               redirect_thread_id,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               out_thread_id,
  output logic [1:0]         halted
);

`ifdef THREAD_SKIP_EN
  localparam logic SKIP_EN = 1'b1;
`else
  localparam logic SKIP_EN = 1'b0;
`endif

  logic [PC_W-1:0]        pc_q [NUM_THREADS];
  logic [PC_W-1:0]        pc_d [NUM_THREADS];
  logic [THREAD_W-1:0]    rr_q, rr_d;
  logic [NUM_THREADS-1:0] halted_q, halted_d;
  logic                   out_valid_q, out_valid_d;
  fetch_out_t             out_q, out_d;

  logic [NUM_THREADS-1:0] eligible;
  logic [THREAD_W-1:0]    sel;
  logic [THREAD_W-1:0]    fetch_tid;
  logic                   issue;
  logic                   flush;
  logic                   adv;
  logic                   go;

  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      eligible[t] = !thread_stall[t] && !halted_q[t] &&
                    !(redirect_valid && (redirect_thread_id == THREAD_W'(t)));
    end
  end

  thread_select u_select (
    .rr       (rr_q),
    .eligible (eligible),
    .skip_en  (SKIP_EN),
    .sel      (sel),
    .issue    (issue)
  );

  // A flush empties the output slot, so the other thread may take it the same cycle.
  assign flush     = redirect_valid && out_valid_q && (out_q.tid == redirect_thread_id);
  assign adv       = !out_valid_q || out_ready || flush;
  assign go        = adv && issue;
  assign fetch_tid = go ? sel : rr_q;
  assign imem_addr = rst ? T0_RESET_PC : pc_q[fetch_tid];

  always_comb begin
    pc_d        = pc_q;
    rr_d        = rr_q;
    halted_d    = halted_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (adv) begin
      if (issue) begin
        out_valid_d   = 1'b1;
        out_d.instr   = imem_data;
        out_d.pc      = pc_q[sel];
        out_d.tid     = sel;
        pc_d[sel]     = pc_q[sel] + PC_W'(1);
        rr_d          = ~sel;
        if (is_halt(imem_data)) begin
          halted_d[sel] = 1'b1;
        end
      end else begin
        out_valid_d = 1'b0;
        rr_d        = ~rr_q;
      end
    end
    // Redirect lands last so it overrides both the increment and a same-cycle halt.
    if (redirect_valid) begin
      pc_d[redirect_thread_id]     = redirect_pc;
      halted_d[redirect_thread_id] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q[0]     <= T0_RESET_PC;
      pc_q[1]     <= T1_RESET_PC;
      rr_q        <= '0;
      halted_q    <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      pc_q[0]     <= pc_d[0];
      pc_q[1]     <= pc_d[1];
      rr_q        <= rr_d;
      halted_q    <= halted_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_instr     = out_q.instr;
  assign out_pc        = out_q.pc;
  assign out_thread_id = out_q.tid;
  assign halted        = halted_q;

endmodule

// File: tb/tb_thread_fetch.sv
// Bench for thread_fetch: directed literal checks, then random stall/ready/redirect/reset traffic
// compared every cycle against a thread-level reference model.
module tb_thread_fetch;

`ifdef THREAD_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [1:0]  thread_stall;
  logic        redirect_valid;
  logic        redirect_thread_id;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [7:0]  out_pc;
  logic        out_thread_id;
  logic [1:0]  halted;

  logic [15:0] mem [256];
  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  thread_fetch dut (
    .clk                (clk),
    .rst                (rst),
    .imem_addr          (imem_addr),
    .imem_data          (imem_data),
    .thread_stall       (thread_stall),
    .redirect_valid     (redirect_valid),
    .redirect_thread_id (redirect_thread_id),
    .redirect_pc        (redirect_pc),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_instr          (out_instr),
    .out_pc             (out_pc),
    .out_thread_id      (out_thread_id),
    .halted             (halted)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: per-thread PC and halt flags, the preferred thread, and the delivered slot.
  logic [7:0]  m_pc [2];
  bit          m_halt [2];
  int          m_rr;
  bit          m_v;
  logic [15:0] m_instr;
  logic [7:0]  m_opc;
  int          m_tid;

  function automatic bit elig(input int t);
    return !thread_stall[t] && !m_halt[t] &&
           !(redirect_valid && (int'(redirect_thread_id) == t));
  endfunction

  // -1: slot held by backpressure, -2: bubble, otherwise the thread that issues.
  function automatic int pick();
    bit fl, adv;
    fl  = redirect_valid && m_v && (m_tid == int'(redirect_thread_id));
    adv = !m_v || out_ready || fl;
    if (!adv) return -1;
    if (elig(m_rr)) return m_rr;
    if (SKIP && elig(1 - m_rr)) return 1 - m_rr;
    return -2;
  endfunction

  always @(posedge clk) begin : model
    int          c;
    logic [7:0]  npc [2];
    bit          nh [2];
    int          nrr;
    bit          nv;
    logic [15:0] ni;
    logic [7:0]  nopc;
    int          ntid;
    if (rst) begin
      m_pc[0] <= 8'h00; m_pc[1] <= 8'h80;
      m_halt[0] <= 1'b0; m_halt[1] <= 1'b0;
      m_rr <= 0; m_v <= 1'b0; m_instr <= '0; m_opc <= '0; m_tid <= 0;
    end else begin
      npc = m_pc; nh = m_halt; nrr = m_rr; nv = m_v; ni = m_instr; nopc = m_opc; ntid = m_tid;
      c = pick();
      if (c >= 0) begin
        nv = 1'b1; ni = mem[m_pc[c]]; nopc = m_pc[c]; ntid = c;
        if (ni[15:12] == 4'hF) nh[c] = 1'b1;
        npc[c] = m_pc[c] + 8'd1;
        nrr = 1 - c;
      end else if (c == -2) begin
        nv = 1'b0; nrr = 1 - m_rr;
      end
      if (redirect_valid) begin
        npc[redirect_thread_id] = redirect_pc;
        nh[redirect_thread_id]  = 1'b0;
      end
      m_pc <= npc; m_halt <= nh; m_rr <= nrr; m_v <= nv;
      m_instr <= ni; m_opc <= nopc; m_tid <= ntid;
    end
  end

  always @(negedge clk) begin : compare
    int         c;
    logic [7:0] ea;
    if (chk_en) begin
      c  = pick();
      ea = rst ? 8'h00 : (c >= 0 ? m_pc[c] : m_pc[m_rr]);
      chk("imem_addr", 32'(imem_addr), 32'(ea));
      chk("out_valid", 32'(out_valid), 32'(m_v));
      chk("halted", 32'(halted), {30'd0, m_halt[1], m_halt[0]});
      if (m_v) begin
        chk("out_instr", 32'(out_instr), 32'(m_instr));
        chk("out_pc", 32'(out_pc), 32'(m_opc));
        chk("out_thread_id", 32'(out_thread_id), 32'(m_tid));
      end
    end
  end

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic [7:0] pc, input logic tid);
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_pc"}, 32'(out_pc), 32'(pc));
    chk({nm, "_tid"}, 32'(out_thread_id), 32'(tid));
  endtask

  initial begin
    rst = 1'b1; thread_stall = 2'b00; redirect_valid = 1'b0;
    redirect_thread_id = 1'b0; redirect_pc = 8'h00; out_ready = 1'b1;
    for (int a = 0; a < 256; a++) mem[a] = {8'h10, 8'(a)};
    mem[8'h82] = 16'hF000;

    edge_step();
    chk_en = 1'b1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", 32'(out_instr), 32'd0);
    chk("rst_pc", 32'(out_pc), 32'd0);
    chk("rst_tid", 32'(out_thread_id), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'h00);
    edge_step();
    rst = 1'b0;

    edge_step(); chk_out("seq0", 8'h00, 1'b0);
    chk("seq0_instr", 32'(out_instr), 32'h1000);
    edge_step(); chk_out("seq1", 8'h80, 1'b1);
    edge_step(); chk_out("seq2", 8'h01, 1'b0);
    edge_step(); chk_out("seq3", 8'h81, 1'b1);
    edge_step();
    edge_step(); chk_out("halt_fetch", 8'h82, 1'b1);
    chk("halt_instr", 32'(out_instr), 32'hF000);
    chk("halt_set", 32'(halted), 32'b10);

    redirect_valid = 1'b1; redirect_thread_id = 1'b1; redirect_pc = 8'h90;
    edge_step(); chk_out("redir_other", 8'h03, 1'b0);
    chk("halt_cleared", 32'(halted), 32'b00);
    redirect_valid = 1'b0;
    edge_step(); chk_out("resume_t1", 8'h90, 1'b1);

    out_ready = 1'b0;
    repeat (4) edge_step();
    chk_out("frozen", 8'h90, 1'b1);
    out_ready = 1'b1;
    edge_step(); chk_out("release", 8'h04, 1'b0);

    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_thread_id = 1'b0; redirect_pc = 8'h40;
    edge_step(); chk_out("flush_t0", 8'h91, 1'b1);
    redirect_valid = 1'b0; out_ready = 1'b1;
    edge_step(); chk_out("redir_t0", 8'h40, 1'b0);

    for (int a = 0; a < 256; a++)
      mem[a] = {(($urandom_range(0, 24) == 0) ? 4'hF : 4'h1), 4'($urandom), 8'(a)};

    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst                = ($urandom_range(0, 299) == 0);
      thread_stall       = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      out_ready          = ($urandom_range(0, 9) < 7);
      redirect_valid     = ($urandom_range(0, 9) == 0);
      redirect_thread_id = 1'($urandom);
      redirect_pc        = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(8'hFC, 8'hFF))
                                                       : 8'($urandom);
      edge_step();
    end

    rst = 1'b0; redirect_valid = 1'b0; thread_stall = 2'b00;
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
